// File: rtl/fc_neuron_mac_ctrl.sv
// fc_neuron_mac_ctrl: sequencer and accumulator for one fully-connected neuron.
// Fetches (activation, weight) pairs, drives an external Booth multiplier,
// accumulates NUM_INPUTS products plus a bias, then saturates (and optionally
// ReLUs) the sum and presents it on a valid/ready output.
// Ports:
//   clk, reset                      clock, async active-high reset
//   start, bias                     begin a neuron, bias sampled with start
//   in_valid/in_ready/in_act/in_weight   input pair stream
//   mul_m/mul_r/mul_enable/mul_reset     multiplier drive
//   mul_finish/mul_result                multiplier response
//   out_valid/out_ready/out_data         neuron result stream
//   busy                            high whenever not idle
module fc_neuron_mac_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned ACC_W      = 24,
    parameter bit          RELU       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_weight,
    output logic [DATA_W-1:0] mul_m,
    output logic [DATA_W-1:0] mul_r,
    output logic              mul_enable,
    output logic              mul_reset,
    input  logic              mul_finish,
    input  logic [DATA_W-1:0] mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int unsigned CNT_W = 8;

    localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((64'd1 << (DATA_W - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN = ~SAT_MAX;
    localparam logic        [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic        [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_FINAL,
        S_OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic        [CNT_W-1:0]   count_q, count_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [DATA_W-1:0]  mul_m_q, mul_m_d;
    logic        [DATA_W-1:0]  mul_r_q, mul_r_d;
    logic        [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic                      mul_enable_q, mul_enable_d;
    logic                      mul_reset_q, mul_reset_d;
    logic                      busy_q, busy_d;
    logic        [DATA_W-1:0]  sat_c;

    // Clamp the accumulator into the output range, then apply optional ReLU.
    always_comb begin
        if (acc_q > SAT_MAX) begin
            sat_c = OUT_MAX;
        end else if (acc_q < SAT_MIN) begin
            sat_c = OUT_MIN;
        end else begin
            sat_c = DATA_W'(acc_q);
        end
        if (RELU && sat_c[DATA_W-1]) begin
            sat_c = '0;
        end
    end

    // Next-state logic; per-state outputs are derived from the next state so
    // the registered outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mul_m_d     = mul_m_q;
        mul_r_d     = mul_r_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = ACC_W'($signed(bias));
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid && in_ready_q) begin
                    mul_m_d = in_act;
                    mul_r_d = in_weight;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_finish) begin
                    acc_d   = acc_q + ACC_W'($signed(mul_result));
                    count_d = count_q + CNT_W'(1);
                    state_d = (count_q == CNT_W'(NUM_INPUTS - 1)) ? S_FINAL : S_FETCH;
                end
            end
            S_FINAL: begin
                out_data_d  = sat_c;
                out_valid_d = 1'b1;
                state_d     = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_ready && out_valid_q) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d   = (state_d == S_FETCH);
        mul_enable_d = (state_d == S_LOAD) || (state_d == S_WAIT);
        mul_reset_d  = (state_d == S_LOAD);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            acc_q        <= '0;
            mul_m_q      <= '0;
            mul_r_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            mul_enable_q <= 1'b0;
            mul_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            mul_m_q      <= mul_m_d;
            mul_r_q      <= mul_r_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            mul_enable_q <= mul_enable_d;
            mul_reset_q  <= mul_reset_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mul_m      = mul_m_q;
    assign mul_r      = mul_r_q;
    assign mul_enable = mul_enable_q;
    assign mul_reset  = mul_reset_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fc_neuron_mac_ctrl.sv
// Bench for fc_neuron_mac_ctrl: two instances (RELU=1 and RELU=0) share one
// stimulus stream, each with its own behavioural Booth multiplier model.
module tb_fc_neuron_mac_ctrl;

    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [15:0] bias;
    logic in_valid;
    logic [15:0] in_act;
    logic [15:0] in_weight;
    logic out_ready;

    logic        in_ready0, mul_enable0, mul_reset0, mul_finish0, out_valid0, busy0;
    logic [15:0] mul_m0, mul_r0, mul_result0, out_data0;
    logic        in_ready1, mul_enable1, mul_reset1, mul_finish1, out_valid1, busy1;
    logic [15:0] mul_m1, mul_r1, mul_result1, out_data1;
    logic [4:0]  mcnt0, mcnt1;

    int checks = 0;
    int errors = 0;
    int nres = 0;
    int nacc = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] va[4];
    logic [15:0] vw[4];

    always #5 clk = ~clk;

    fc_neuron_mac_ctrl #(.DATA_W(16), .NUM_INPUTS(4), .ACC_W(24), .RELU(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready0), .in_act(in_act), .in_weight(in_weight),
        .mul_m(mul_m0), .mul_r(mul_r0), .mul_enable(mul_enable0), .mul_reset(mul_reset0),
        .mul_finish(mul_finish0), .mul_result(mul_result0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
    );

    fc_neuron_mac_ctrl #(.DATA_W(16), .NUM_INPUTS(4), .ACC_W(24), .RELU(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready1), .in_act(in_act), .in_weight(in_weight),
        .mul_m(mul_m1), .mul_r(mul_r1), .mul_enable(mul_enable1), .mul_reset(mul_reset1),
        .mul_finish(mul_finish1), .mul_result(mul_result1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
    );

    // Q5.10 fixed-point product, truncated back to 16 bits.
    function automatic logic [15:0] fx_mul(input logic [15:0] a, input logic [15:0] w);
        logic signed [31:0] p;
        p = $signed(a) * $signed(w);
        return p[25:10];
    endfunction

    // Multiplier models: load on mul_reset, finish DATA_W+1 enabled cycles later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_finish0 <= 1'b0; mcnt0 <= '0; mul_result0 <= '0;
        end else if (mul_reset0) begin
            mul_finish0 <= 1'b0; mcnt0 <= '0; mul_result0 <= fx_mul(mul_m0, mul_r0);
        end else if (!mul_enable0) begin
            mul_finish0 <= 1'b0;
        end else if (!mul_finish0) begin
            if (mcnt0 == 5'(DATA_W)) mul_finish0 <= 1'b1;
            mcnt0 <= mcnt0 + 5'd1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_finish1 <= 1'b0; mcnt1 <= '0; mul_result1 <= '0;
        end else if (mul_reset1) begin
            mul_finish1 <= 1'b0; mcnt1 <= '0; mul_result1 <= fx_mul(mul_m1, mul_r1);
        end else if (!mul_enable1) begin
            mul_finish1 <= 1'b0;
        end else if (!mul_finish1) begin
            if (mcnt1 == 5'(DATA_W)) mul_finish1 <= 1'b1;
            mcnt1 <= mcnt1 + 5'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier protocol tracking on instance 0.
    always @(negedge clk) begin
        if (start && !busy0) begin
            nres = 0;
            nacc = 0;
        end else begin
            if (mul_reset0) begin
                nres++;
                chk("enable_with_load", 32'(mul_enable0), 32'd1);
            end
            if (mul_finish0 && mul_enable0 && !mul_reset0) nacc++;
        end
    end

    // Output monitors: pop an expectation at every output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                chk("unexpected_out0", 32'(out_data0), 32'hFFFF_FFFF);
            end else begin
                chk("out_data_relu", 32'(out_data0), 32'(exp_q0.pop_front()));
            end
            chk("mul_reset_pulses", 32'(nres), 32'd4);
            chk("accumulations", 32'(nacc), 32'd4);
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid1 && out_ready) begin
            if (exp_q1.size() == 0) begin
                chk("unexpected_out1", 32'(out_data1), 32'hFFFF_FFFF);
            end else begin
                chk("out_data_lin", 32'(out_data1), 32'(exp_q1.pop_front()));
            end
        end
    end

    task automatic do_start(input logic [15:0] b);
        int n;
        n = 0;
        while (busy0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("idle_timeout", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_pair(input int i, input bit stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("fetch_timeout", 32'(in_ready0), 32'd1);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("stall_in_ready", 32'(in_ready0), 32'd1);
                chk("stall_mul_enable", 32'(mul_enable0), 32'd0);
            end
        end
        in_valid  = 1'b1;
        in_act    = va[i];
        in_weight = vw[i];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_neuron(input logic [15:0] b, input logic [15:0] e_relu,
                              input logic [15:0] e_lin, input bit stall_in, input bit stall_out);
        int n;
        logic [15:0] held;
        out_ready = !stall_out;
        exp_q0.push_back(e_relu);
        exp_q1.push_back(e_lin);
        do_start(b);
        for (int i = 0; i < 4; i++) feed_pair(i, stall_in && (i == 1));
        if (stall_out) begin
            n = 0;
            while (!out_valid0 && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) chk("out_valid_timeout", 32'(out_valid0), 32'd1);
            held = out_data0;
            for (int k = 0; k < 10; k++) begin
                if (k == 4) begin
                    @(posedge clk); #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
                @(negedge clk);
                chk("hold_out_valid", 32'(out_valid0), 32'd1);
                chk("hold_out_data", 32'(out_data0), 32'(held));
                chk("hold_busy", 32'(busy0), 32'd1);
            end
            @(posedge clk); #1 out_ready = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (busy0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("done_timeout", 32'(busy0), 32'd0);
        chk("out_valid_cleared", 32'(out_valid0), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},       32'(busy0),       32'd0);
        chk({tag, "_in_ready"},   32'(in_ready0),   32'd0);
        chk({tag, "_mul_enable"}, 32'(mul_enable0), 32'd0);
        chk({tag, "_mul_reset"},  32'(mul_reset0),  32'd0);
        chk({tag, "_mul_m"},      32'(mul_m0),      32'd0);
        chk({tag, "_mul_r"},      32'(mul_r0),      32'd0);
        chk({tag, "_out_valid"},  32'(out_valid0),  32'd0);
        chk({tag, "_out_data"},   32'(out_data0),   32'd0);
    endtask

    task automatic set_vec(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] a3, input logic [15:0] w);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
        for (int i = 0; i < 4; i++) vw[i] = w;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_act    = '0;
        in_weight = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // 0.25 + 1.0 + 2.0 + 0.5 - 1.0 = 2.75, with both stall patterns
        set_vec(16'h0400, 16'h0800, 16'h0200, 16'hFC00, 16'h0400);
        run_neuron(16'h0100, 16'h0B00, 16'h0B00, 1'b1, 1'b1);

        // 0.25 - 2.5 = -2.25: ReLU clamps, linear instance passes it through
        set_vec(16'h0400, 16'h0800, 16'h0200, 16'hFC00, 16'hFC00);
        run_neuron(16'h0100, 16'h0000, 16'hF700, 1'b0, 1'b0);

        // 4 * 31.0 = 124 saturates high
        set_vec(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h0400);
        run_neuron(16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);

        // 4 * -31.0 = -124 saturates low
        set_vec(16'h8400, 16'h8400, 16'h8400, 16'h8400, 16'h0400);
        run_neuron(16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0);

        // Reset in the middle of the third multiply abandons the neuron
        set_vec(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h0400);
        out_ready = 1'b1;
        do_start(16'h0100);
        for (int i = 0; i < 3; i++) feed_pair(i, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_wait_enable", 32'(mul_enable0), 32'd1);
        chk("mid_wait_reset", 32'(mul_reset0), 32'd0);
        #1 reset = 1'b1;
        #1;
        check_reset_state("midreset");
        @(posedge clk); #1 reset = 1'b0;

        // Fresh neuron after the abort must carry no residue
        set_vec(16'h0400, 16'h0800, 16'h0200, 16'hFC00, 16'h0400);
        run_neuron(16'h0100, 16'h0B00, 16'h0B00, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("pending_relu", 32'(exp_q0.size()), 32'd0);
        chk("pending_lin", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_neuron_mac_ctrl.md
Name: fc_neuron_mac_ctrl

Overview:
- Sequencer and accumulator for one fully-connected neuron.
- Sits directly upstream and downstream of the FC Booth multiplier:
  - fetches (activation, weight) pairs from a valid/ready stream;
  - drives the multiplier's enable/reset/M/R;
  - consumes its finish flag and 16-bit fixed-point product.
- Accumulates NUM_INPUTS products plus a bias, then optionally applies ReLU and saturates.
- Emits one neuron output over a valid/ready handshake.

Parameters:
- DATA_W, 16, width of activations, weights, bias, products and output (signed Q5.10).
- NUM_INPUTS, 4, products accumulated per neuron (1..255).
- ACC_W, 24, internal signed accumulator width.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass through.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse in IDLE; begins a neuron and latches bias.
- bias  in  DATA_W  signed bias, sampled with start.
- in_valid  in  1  activation/weight pair valid.
- in_ready  out  1  controller accepts pair.
- in_act  in  DATA_W  signed activation.
- in_weight  in  DATA_W  signed weight.
- mul_m  out  DATA_W  multiplicand to multiplier (registered activation).
- mul_r  out  DATA_W  multiplier operand (registered weight).
- mul_enable  out  1  multiplier enable.
- mul_reset  out  1  multiplier load pulse.
- mul_finish  in  1  multiplier done flag.
- mul_result  in  DATA_W  signed fixed-point product, valid while mul_finish=1.
- out_valid  out  1  neuron result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  saturated, optionally ReLU'd neuron output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, immediate:
  - state=IDLE, count=0, acc=0;
  - in_ready=0, mul_enable=0, mul_reset=0, mul_m=0, mul_r=0;
  - out_valid=0, out_data=0, busy=0.
  - Reset mid-operation abandons the neuron. The multiplier is left disabled. No partial output is produced.
- All outputs are registered. Multiplier operand outputs change only in FETCH.
- States and transitions:
  - IDLE:
    - start=1 → acc = sign-extended bias, count=0 → FETCH.
    - start is ignored in all other states.
  - FETCH:
    - in_ready=1.
    - On in_valid&in_ready: latch mul_m=in_act, mul_r=in_weight → LOAD.
  - LOAD (1 cycle):
    - mul_enable=1, mul_reset=1 → WAIT.
  - WAIT:
    - mul_enable=1, mul_reset=0.
    - On mul_finish=1: acc += sign-extended mul_result; count += 1.
    - If count was NUM_INPUTS-1 → FINAL, else → FETCH.
    - mul_finish is only sampled in WAIT. A stale finish from the previous product is impossible because LOAD re-arms the multiplier.
  - FINAL (1 cycle):
    - mul_enable=0.
    - Saturate acc to DATA_W: >32767 → 0x7FFF, <-32768 → 0x8000.
    - If RELU and result negative → 0.
    - Register into out_data, set out_valid=1 → OUTPUT.
  - OUTPUT:
    - Hold out_data/out_valid stable until out_ready=1.
    - On handshake: out_valid=0 → IDLE.
- Width/arithmetic:
  - Two's complement throughout.
  - ACC_W wraps silently; it is sized so that NUM_INPUTS·32767 + bias never overflows at defaults.
  - Saturation occurs only in FINAL.
- Latency:
  - Per pair: 1 FETCH handshake cycle + 1 LOAD cycle + multiplier time (finish seen DATA_W+1 cycles after the load edge) + 1 accumulate edge.
  - Plus 1 FINAL cycle before out_valid.
- in_valid while not in FETCH is ignored; in_ready=0.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Basic sum, RELU=1: bias=0x0100; acts 0x0400,0x0800,0x0200,0xFC00; weights all 0x0400 → out_data=0x0B00 (2.75), out_valid held until out_ready.
- ReLU clamp: same acts, weights all 0xFC00, bias=0x0100 → sum −2.25 → out_data=0x0000.
- Saturation, RELU=0: acts all 0x7C00, weights 0x0400, bias 0 → out_data=0x7FFF. Acts 0x8400 → out_data=0x8000.
- Handshake stalls:
  - in_valid low for 5 cycles in FETCH → state holds, mul_enable=0.
  - out_ready low 10 cycles → out_data constant, no new start accepted.
- Multiplier protocol: check exactly one mul_reset pulse per pair, mul_enable high LOAD through WAIT, and 4 accumulations per neuron.
- Reset mid-WAIT of pair 3 → all outputs 0 immediately, busy=0; a following start produces a correct fresh result with no residue.
